// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that shares the 8-digit seven-segment display between four 32-bit sources.
// Each granted word is held for HOLD_CYCLES cycles; a force mode tracks one chosen source live.
module seg_disp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_req_valid,
  input  logic [127:0] i_req_data,
  input  logic         i_force_en,
  input  logic [1:0]   i_force_sel,
  output logic [3:0]   o_req_ack,
  output logic [31:0]  o_disp_data,
  output logic [1:0]   o_disp_src,
  output logic         o_disp_valid,
  output logic [7:0]   o_blank_mask,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StForce
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_last_grant;
  logic [3:0]       r_req_ack;
  logic [31:0]      r_disp_data;
  logic [1:0]       r_disp_src;
  logic             r_disp_valid;
  logic [7:0]       r_blank_mask;
  logic             r_busy;

  logic             w_grant_found;
  logic [1:0]       w_grant_idx;
  logic [31:0]      w_grant_word;
  logic [31:0]      w_force_word;

  // Digit j is blanked when it and every more significant nibble are zero; digit 0 always shows.
  function automatic logic [7:0] f_blank(input logic [31:0] d);
    logic [7:0] m;
    m = '0;
    for (int j = 1; j < 8; j++) begin
      m[j] = ((d >> (4 * j)) == 32'd0);
    end
    return m;
  endfunction

  // Search starts one past the previous grant so every requester gets a turn.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = r_last_grant;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = r_last_grant + 2'(k);
      if (!w_grant_found && i_req_valid[cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = cand;
      end
    end
  end

  assign w_grant_word = i_req_data[32 * w_grant_idx +: 32];
  assign w_force_word = i_req_data[32 * i_force_sel +: 32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last_grant <= 2'd3;
      r_req_ack    <= '0;
      r_disp_data  <= '0;
      r_disp_src   <= '0;
      r_disp_valid <= 1'b0;
      r_blank_mask <= 8'hFE;
      r_busy       <= 1'b0;
    end else begin
      r_req_ack <= '0;
      if (i_force_en) begin
        // Force overrides any pending grant and abandons a hold in progress.
        r_state      <= StForce;
        r_disp_data  <= w_force_word;
        r_disp_src   <= i_force_sel;
        r_disp_valid <= 1'b1;
        r_blank_mask <= f_blank(w_force_word);
        r_cnt        <= '0;
        r_busy       <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_grant_found) begin
              r_state      <= StHold;
              r_disp_data  <= w_grant_word;
              r_disp_src   <= w_grant_idx;
              r_disp_valid <= 1'b1;
              r_blank_mask <= f_blank(w_grant_word);
              r_req_ack    <= 4'(1) << w_grant_idx;
              r_last_grant <= w_grant_idx;
              r_cnt        <= CNT_W'(HOLD_CYCLES - 1);
              r_busy       <= 1'b1;
            end
          end
          StHold: begin
            if (r_cnt == '0) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          StForce: begin
            r_state      <= StIdle;
            r_last_grant <= i_force_sel;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_req_ack    = r_req_ack;
  assign o_disp_data  = r_disp_data;
  assign o_disp_src   = r_disp_src;
  assign o_disp_valid = r_disp_valid;
  assign o_blank_mask = r_blank_mask;
  assign o_busy       = r_busy;

endmodule
